// File: rtl/mmio_io_peripherals.sv
// rtl/mmio_io_peripherals.sv - button/switch conditioning and signed decimal 4-digit seven-segment display
module mmio_io_peripherals #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_raw,
    input  logic [N-1:0] sw_raw,
    input  logic [N-1:0] p1_value,
    output logic         p2_button,
    output logic [N-1:0] p3_switches,
    output logic [6:0]   seg,
    output logic [3:0]   an
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SC_W = $clog2(N + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'd0:    hex7 = 7'b1000000;
            4'd1:    hex7 = 7'b1111001;
            4'd2:    hex7 = 7'b0100100;
            4'd3:    hex7 = 7'b0110000;
            4'd4:    hex7 = 7'b0011001;
            4'd5:    hex7 = 7'b0010010;
            4'd6:    hex7 = 7'b0000010;
            4'd7:    hex7 = 7'b1111000;
            4'd8:    hex7 = 7'b0000000;
            4'd9:    hex7 = 7'b0010000;
            default: hex7 = SEG_BLANK;
        endcase
    endfunction

    logic         btn_s1, btn_s2;
    logic [N-1:0] sw_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            sw_s1       <= '0;
            p3_switches <= '0;
        end else begin
            btn_s1      <= btn_raw;
            btn_s2      <= btn_s1;
            sw_s1       <= sw_raw;
            p3_switches <= sw_s1;
        end
    end

    // Any cycle where the synced button agrees with the output restarts the count.
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            p2_button <= 1'b0;
        end else if (btn_s2 == p2_button) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            p2_button <= btn_s2;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    state_t          state, state_next;
    logic [N-1:0]    latched, mag;
    logic            neg;
    logic [11:0]     bcd, bcd_adj;
    logic [SC_W-1:0] sc;
    logic [6:0]      dig [4];
    logic [3:0]      hund, tens, units;

    assign hund  = bcd[11:8];
    assign tens  = bcd[7:4];
    assign units = bcd[3:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (p1_value != latched) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (sc == SC_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digit registers change only in DONE, so a partial conversion is never displayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched <= '0;
            mag     <= '0;
            neg     <= 1'b0;
            bcd     <= '0;
            sc      <= '0;
            dig[0]  <= SEG_ZERO;
            dig[1]  <= SEG_BLANK;
            dig[2]  <= SEG_BLANK;
            dig[3]  <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (p1_value != latched) latched <= p1_value;
                end
                LOAD: begin
                    neg <= latched[N-1];
                    mag <= latched[N-1] ? (~latched + N'(1)) : latched;
                    bcd <= '0;
                    sc  <= SC_W'(N);
                end
                SHIFT: begin
                    bcd <= {bcd_adj[10:0], mag[N-1]};
                    mag <= {mag[N-2:0], 1'b0};
                    sc  <= sc - SC_W'(1);
                end
                DONE: begin
                    dig[3] <= neg ? SEG_MINUS : SEG_BLANK;
                    dig[2] <= (hund != 4'd0) ? hex7(hund) : SEG_BLANK;
                    dig[1] <= (hund != 4'd0 || tens != 4'd0) ? hex7(tens) : SEG_BLANK;
                    dig[0] <= hex7(units);
                end
                default: ;
            endcase
        end
    end

    logic [RF_W-1:0] rf_cnt;
    logic [1:0]      idx, idx_inc;

    assign idx_inc = idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_cnt <= '0;
            idx    <= 2'd0;
            an     <= 4'b1110;
            seg    <= SEG_ZERO;
        end else if (rf_cnt == RF_W'(REFRESH_CYCLES - 1)) begin
            rf_cnt <= '0;
            idx    <= idx_inc;
            an     <= ~(4'b0001 << idx_inc);
            seg    <= dig[idx_inc];
        end else begin
            rf_cnt <= rf_cnt + RF_W'(1);
            seg    <= dig[idx];
        end
    end

endmodule

// File: doc/mmio_io_peripherals.md
Name: mmio_io_peripherals

Overview:
- Board-side end of the data memory's memory-mapped I/O ports.
- Turns the raw push button and slide switches into the clean button (address 254) and switch (address 255) read values.
- Takes the signed store value for address 253 and shows it in decimal on a 4-digit multiplexed seven-segment display.
- Instantiated at top level between the FPGA pins and the data memory's ReadP2/ReadP3/WriteP1 ports.

Parameters:
N, 8, data width of switch and display paths; legal range 2..9 so the magnitude fits 3 BCD digits
DEBOUNCE_CYCLES, 500000, cycles the synchronized button must stay stable before the output changes
REFRESH_CYCLES, 50000, cycles each display digit stays enabled

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_raw  in  1  raw push button, asynchronous, bouncy
sw_raw  in  N  raw slide switches, asynchronous
p1_value  in  N  signed value last stored to address 253
p2_button  out  1  debounced button, fed to the address 254 read path
p3_switches  out  N  synchronized switches, fed to the address 255 read path
seg  out  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}
an  out  4  digit anodes, active-low one-hot; an[0] is the units digit

Behaviour:
- Reset (synchronous, active-high) sets all state; it takes priority at every clock edge, including mid-debounce and mid-conversion:
  - p2_button=0, p3_switches=0
  - debounce count=0, conversion FSM=IDLE, latched display value=0
  - digit registers: units "0", others blank
  - mux index=0, an=4'b1110, seg=7'b1000000
- Synchronizers: two-flop on btn_raw and each sw_raw bit, reset to 0.
  - p3_switches = second sync stage; latency 2 cycles; no debounce.
- Debounce:
  - If synced button equals p2_button, the count clears.
  - Otherwise the count increments each cycle.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, p2_button takes the synced value on that edge and the count clears.
  - A single-cycle glitch restarts the count.
  - Total latency: 2 + DEBOUNCE_CYCLES cycles after a stable edge on btn_raw.
- Conversion FSM: states IDLE, LOAD, SHIFT, DONE.
  - IDLE: if p1_value != latched value, latch p1_value and go to LOAD; else stay.
  - LOAD: record sign bit; magnitude = two's-complement absolute value, N-bit unsigned (-128 gives 128, no overflow); clear BCD scratch; shift counter=N.
  - SHIFT: one double-dabble step per cycle (add 3 to any BCD nibble >=5, then shift left one bit); decrement counter; at 0 go to DONE.
  - DONE: update all four digit registers in one edge, then return to IDLE.
  - Latency from p1_value change to new digits: N+3 cycles (11 for N=8).
  - If p1_value changes during conversion, the current conversion completes. IDLE then detects the mismatch and converts again, so the display ends on the newest value.
  - Digits never show a partial result.
- Digit contents:
  - Digit 3: minus (seg=7'b0111111) if negative, blank (7'b1111111) otherwise.
  - Digits 2..1: hundreds and tens, with leading-zero blanking; tens is shown whenever hundreds is shown.
  - Digit 0: units, always shown.
  - Hex encodings for 0..9: standard active-low common-anode patterns, e.g. 0=1000000, 1=1111001, 8=0000000.
- Multiplexing:
  - A refresh counter wraps at REFRESH_CYCLES-1; on wrap the mux index advances 0->1->2->3->0.
  - an and seg are registered and change on the same edge, so there is no ghosting cycle.
  - Exactly one an bit is low at all times after reset.

Test Plan:
- Reset with p1_value=0 -> an=1110, seg=1000000; p2_button=0; p3_switches=0; FSM stays IDLE.
- sw_raw=8'hA5 -> p3_switches=8'hA5 exactly 2 cycles later.
- DEBOUNCE_CYCLES=8: btn_raw pulses 1 for 3 cycles, then 0 -> p2_button stays 0. Then btn_raw held 1 -> p2_button rises exactly 10 cycles after the edge.
- p1_value=8'sd123 -> after 11 cycles, cycling the mux (REFRESH_CYCLES=4) shows digits 3..0 = blank,1,2,3. Then p1_value=-5 -> digits = minus, blank, blank, 5.
- p1_value=-128 -> minus,1,2,8. Then p1_value=-1 applied during SHIFT -> digits show -128 first, then settle to minus, blank, blank, 1 without showing an intermediate value.
- rst asserted mid-conversion and mid-debounce -> next cycle matches the reset values above. After release with p1_value=42, the display reaches blank, blank, 4, 2 in 11 cycles.
